reg_bank_arbiter: RTL and testbench

- Round-robin arbiter and write/read sequencer for a small bank of enable-gated D-type registers (DEPTH words of W bits).
- Several requesters share the bank. The block owns the bank storage and generates the per-word load enables, so only one word is written per transaction.
- Sits between requester logic (counters, FSMs) and the shared register storage.

---
 rtl/reg_bank_arbiter.sv | 143 ++++++++++++++
 tb/tb_reg_bank_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter that sequences single-word writes/reads into a small
// enable-gated register bank it owns; one transaction per IDLE->GRANT->RELEASE pass.
module reg_bank_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 4,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     we,
    input  logic [N_REQ*AW-1:0]  addr,
    input  logic [N_REQ*W-1:0]   wdata,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     ack,
    output logic [W-1:0]         rdata,
    output logic [DEPTH*W-1:0]   bank_q,
    output logic                 busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [PW-1:0]       last;
    logic [PW-1:0]       winner;
    logic                any_req;
    int unsigned         scan_idx;
    logic [W-1:0]        bank [DEPTH];
    logic [DEPTH-1:0]    load_en;
    logic                sel_we;
    logic [AW-1:0]       sel_addr;
    logic [W-1:0]        sel_wdata;
    int unsigned         sel_idx;
    logic [W-1:0]        rd_word;

    // Rotating-priority scan: first set req bit after the last winner, wrapping.
    always_comb begin
        winner   = last;
        any_req  = 1'b0;
        scan_idx = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            scan_idx = (32'(last) + k) % N_REQ;
            if (!any_req && req[scan_idx]) begin
                any_req = 1'b1;
                winner  = PW'(scan_idx);
            end
        end
    end

    // While granted, `last` names the owner, so it selects the active request.
    always_comb begin
        sel_we    = we[last];
        sel_addr  = addr[32'(last)*AW +: AW];
        sel_wdata = wdata[32'(last)*W +: W];
        sel_idx   = 32'(sel_addr);
        rd_word   = '0;
        load_en   = '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            if (sel_idx == j) begin
                rd_word    = bank[j];
                load_en[j] = (state == GRANT) && sel_we;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                bank[j] <= '0;
            end
        end else begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (load_en[j]) begin
                    bank[j] <= sel_wdata;
                end
            end
        end
    end

    always_comb begin
        bank_q = '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            bank_q[j*W +: W] = bank[j];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = GRANT;
            GRANT:   state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt   <= '0;
            ack   <= '0;
            rdata <= '0;
            last  <= PW'(N_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt  <= N_REQ'(1) << winner;
                        last <= winner;
                    end
                end
                GRANT: begin
                    ack   <= gnt;
                    rdata <= rd_word;
                end
                RELEASE: begin
                    gnt <= '0;
                    ack <= '0;
                end
                default: begin
                    gnt <= '0;
                    ack <= '0;
                end
            endcase
        end
    end

    always_comb begin
        busy = (state != IDLE);
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Scoreboard bench for reg_bank_arbiter: a reference bank and rotating pointer
// predict each acknowledged transaction; a DEPTH=3 instance covers out-of-range addresses.
module tb_reg_bank_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req = '0, we = '0;
    logic [7:0]  addr = '0;
    logic [15:0] wdata = '0;
    logic [3:0]  gnt, ack, rdata;
    logic [15:0] bank_q;
    logic        busy;

    logic [3:0]  req2 = '0, we2 = '0;
    logic [7:0]  addr2 = '0;
    logic [15:0] wdata2 = '0;
    logic [3:0]  gnt2, ack2, rdata2;
    logic [11:0] bank_q2;
    logic        busy2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [3:0]  ack;
        logic [3:0]  rdata;
        logic [15:0] bank;
    } exp_t;
    exp_t sbq[$];

    logic [3:0] m_bank [4];
    int         m_last = 3;

    reg_bank_arbiter #(.N_REQ(4), .W(4), .DEPTH(4), .AW(2)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .ack(ack), .rdata(rdata), .bank_q(bank_q), .busy(busy)
    );

    reg_bank_arbiter #(.N_REQ(4), .W(4), .DEPTH(3), .AW(2)) dut3 (
        .clk(clk), .reset(reset), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
        .gnt(gnt2), .ack(ack2), .rdata(rdata2), .bank_q(bank_q2), .busy(busy2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (m_last + k) % 4;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [15:0] pack_bank();
        logic [15:0] v;
        for (int j = 0; j < 4; j++) v[j*4 +: 4] = m_bank[j];
        return v;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 4; j++) m_bank[j] = '0;
        m_last = 3;
    endtask

    task automatic push_txn(input int i);
        exp_t e;
        int a;
        a = int'(addr[i*2 +: 2]);
        e.ack   = 4'b0001 << i;
        e.rdata = m_bank[a];
        if (we[i]) m_bank[a] = wdata[i*4 +: 4];
        e.bank  = pack_bank();
        m_last  = i;
        sbq.push_back(e);
    endtask

    task automatic set_req(input int i, input bit w, input logic [1:0] a, input logic [3:0] d);
        we[i] = w;
        addr[i*2 +: 2] = a;
        wdata[i*4 +: 4] = d;
    endtask

    // Held mode keeps req up for n grants and checks ack spacing; drop mode
    // releases each requester once its ack is seen.
    task automatic serve(input logic [3:0] r, input int n, input bit drop);
        logic [3:0] pend;
        int w;
        int budget;
        int last_cyc;
        pend = r;
        budget = 0;
        last_cyc = -1;
        for (int k = 0; k < n; k++) begin
            w = pick(pend);
            if (w < 0) break;
            push_txn(w);
            if (drop) pend[w] = 1'b0;
        end
        @(negedge clk);
        req = r;
        while (sbq.size() != 0 && budget < 200) begin
            @(negedge clk);
            #1;
            budget++;
            if (ack != 0) begin
                if (drop) begin
                    req = req & ~ack;
                end else begin
                    if (last_cyc >= 0) check("ack_spacing", cyc - last_cyc, 3);
                    last_cyc = cyc;
                end
            end
        end
        req = '0;
        check("serve_pending", sbq.size(), 0);
        sbq.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic txn3(input int i, input bit w, input logic [1:0] a, input logic [3:0] d,
                        input logic [3:0] exp_rd, input logic [11:0] exp_bank);
        int budget;
        logic [3:0] exp_ack;
        budget = 0;
        exp_ack = 4'b0001 << i;
        @(negedge clk);
        we2[i] = w;
        addr2[i*2 +: 2] = a;
        wdata2[i*4 +: 4] = d;
        req2[i] = 1'b1;
        while (ack2 == 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("d3_ack", ack2, exp_ack);
        check("d3_rdata", rdata2, exp_rd);
        check("d3_bank_q", bank_q2, exp_bank);
        req2 = '0;
        repeat (2) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            check("gnt_onehot", $onehot0(gnt), 1);
            check("ack_onehot", $onehot0(ack), 1);
            if (ack != 0) begin
                if (sbq.size() == 0) begin
                    check("unexpected_ack", ack, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("ack", ack, e.ack);
                    check("rdata", rdata, e.rdata);
                    check("bank_q", bank_q, e.bank);
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_ack", ack, 0);
        check("rst_rdata", rdata, 0);
        check("rst_busy", busy, 0);
        check("rst_bank_q", bank_q, 0);
        reset = 1'b1;
        @(negedge clk);

        // Test 1: write 0xA to word 2, with cycle-exact latency checks
        set_req(0, 1'b1, 2'd2, 4'hA);
        push_txn(0);
        @(negedge clk);
        req = 4'b0001;
        @(posedge clk); #1;
        check("t1_gnt", gnt, 4'b0001);
        check("t1_busy_g", busy, 1);
        check("t1_ack_early", ack, 0);
        @(posedge clk); #1;
        check("t1_busy_a", busy, 1);
        check("t1_bank_now", bank_q, 16'h0A00);
        req = '0;
        @(posedge clk); #1;
        check("t1_busy_idle", busy, 0);
        check("t1_gnt_idle", gnt, 0);
        check("t1_pending", sbq.size(), 0);
        @(negedge clk);

        // Test 2: requester 2 reads word 2
        set_req(2, 1'b0, 2'd2, 4'h0);
        serve(4'b0100, 1, 1'b1);

        // Test 3: full contention, each requester writes its index to its index
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 2'(i), 4'(i));
        serve(4'b1111, 5, 1'b0);
        check("t3_bank", bank_q, 16'h3210);

        // Test 4: pointer parked on 1, then 0 and 1 both request
        set_req(0, 1'b0, 2'd0, 4'h0);
        set_req(1, 1'b0, 2'd1, 4'h0);
        serve(4'b0010, 1, 1'b1);
        serve(4'b0011, 2, 1'b1);

        // Test 5: reset between grant and write edge
        set_req(0, 1'b1, 2'd3, 4'h5);
        @(negedge clk);
        req = 4'b0001;
        @(posedge clk); #1;
        check("t5_gnt", gnt, 4'b0001);
        #2;
        reset = 1'b0;
        #1;
        check("t5_gnt_rst", gnt, 0);
        check("t5_ack_rst", ack, 0);
        check("t5_busy_rst", busy, 0);
        check("t5_bank_rst", bank_q, 0);
        req = '0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        check("t5_word3", bank_q, 0);
        check("t5_idle", busy, 0);
        serve(4'b0011, 2, 1'b1);

        // Test 6: DEPTH=3 instance, address 3 is out of range
        txn3(0, 1'b1, 2'd2, 4'h7, 4'h0, 12'h700);
        txn3(1, 1'b1, 2'd3, 4'h9, 4'h0, 12'h700);
        txn3(2, 1'b0, 2'd3, 4'h0, 4'h0, 12'h700);
        txn3(3, 1'b0, 2'd2, 4'h0, 4'h7, 12'h700);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
